// File: rtl/ibex_mem_responder_pkg.sv
// ibex_mem_pkg: shared response type, latency bound and index-width helper for the memory responder
package ibex_mem_pkg;
   localparam int unsigned MaxRspLatency = 8;
   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } mem_rsp_t;
   function automatic int unsigned idx_width(input int unsigned words);
      return $clog2(words);
   endfunction
endpackage

// File: rtl/ibex_mem_responder_if.sv
// ibex_mem_responder_if: req/gnt/rvalid memory bus; master drives requests and stall, slave returns grants and responses
interface ibex_mem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stall_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   modport master (output req_i, we_i, be_i, addr_i, wdata_i, stall_i, input gnt_o, rvalid_o, rdata_o, err_o);
   modport slave (input req_i, we_i, be_i, addr_i, wdata_i, stall_i, output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/ibex_mem_responder_rsp_pipe.sv
// ibex_mem_rsp_pipe: Depth-stage valid+response shift register with synchronous flush; payload zeroed when not valid
module ibex_mem_rsp_pipe
   import ibex_mem_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     in_valid,
   input  mem_rsp_t in_rsp,
   output logic     out_valid,
   output mem_rsp_t out_rsp
);
   logic [Depth-1:0] v;
   mem_rsp_t         r [Depth];
   always_ff @(posedge clk_i) begin
      v[0] <= ~rst_i & in_valid;
      r[0] <= (~rst_i & in_valid) ? in_rsp : '0;
      for (int i = 1; i < Depth; i++) begin
         v[i] <= ~rst_i & v[i-1];
         r[i] <= rst_i ? '0 : r[i-1];
      end
   end
   assign out_valid = v[Depth-1];
   assign out_rsp   = r[Depth-1];
endmodule

// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: word SRAM behind req/gnt/rvalid with outstanding limit, stall and fixed-latency in-order responses
module ibex_mem_responder
   import ibex_mem_pkg::*;
#(
   parameter int unsigned MemWords       = 4096,
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int unsigned RspLatency     = 2,
   parameter int unsigned MaxOutstanding = 2
) (
   input logic                 clk_i,
   input logic                 rst_i,
   ibex_mem_responder_if.slave bus
);
   localparam int unsigned IW = idx_width(MemWords);
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   logic [31:0]   mem [MemWords];
   logic [CW-1:0] cnt;
   logic [29:0]   off;
   logic [IW-1:0] idx;
   logic          in_range, gnt, pv;
   mem_rsp_t      rsp, prsp;
   // Word offset from the base; addresses below the base wrap high and fail the range test.
   assign off      = 30'((bus.addr_i - BaseAddr) >> 2);
   assign in_range = off[29:IW] == '0;
   assign idx      = off[IW-1:0];
   assign gnt      = bus.req_i & ~bus.stall_i & ~rst_i & (cnt < CW'(MaxOutstanding));
   assign rsp      = '{err: ~in_range, rdata: (in_range & ~bus.we_i) ? mem[idx] : '0};
   always_ff @(posedge clk_i) begin
      if (gnt & bus.we_i & in_range)
         for (int k = 0; k < 4; k++)
            if (bus.be_i[k]) mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
   end
   always_ff @(posedge clk_i) begin
      cnt <= rst_i ? '0 : cnt + CW'(gnt) - CW'(pv);
   end
   ibex_mem_rsp_pipe #(.Depth(RspLatency)) u_pipe (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .in_valid (gnt),
      .in_rsp   (rsp),
      .out_valid(pv),
      .out_rsp  (prsp)
   );
   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = pv & ~rst_i;
   assign bus.rdata_o  = rst_i ? '0 : prsp.rdata;
   assign bus.err_o    = prsp.err & ~rst_i;
   a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      cnt <= CW'(MaxOutstanding) && RspLatency <= MaxRspLatency);
   a_cnt_min: assert property (@(posedge clk_i) disable iff (rst_i) pv |-> cnt != '0);
   a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.req_i && !gnt |=> bus.req_i && $stable(bus.we_i) && $stable(bus.addr_i)
                            && $stable(bus.be_i) && $stable(bus.wdata_i));
endmodule

// File: tb/tb_ibex_mem_responder.sv
// tb_ibex_mem_responder: randomized and directed scoreboard bench against a queue/array reference model
module tb_ibex_mem_responder;
   localparam int unsigned MW = 64;
   localparam logic [31:0] BA = 32'h0000_1000;
   localparam int unsigned L  = 3;
   localparam int unsigned MO = 2;
   typedef struct {
      int          due;
      logic        err;
      logic [31:0] rdata;
   } exp_t;
   logic        clk = 0;
   logic        rst = 1;
   bit          rnd = 0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   logic [31:0] ref_mem [MW];
   ibex_mem_responder_if bus();
   ibex_mem_responder #(.MemWords(MW), .BaseAddr(BA), .RspLatency(L), .MaxOutstanding(MO)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rnd) begin
      #1 bus.stall_i = ($urandom_range(0, 3) == 0);
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask
   always @(negedge clk) begin
      bit     eg, inr;
      longint a;
      int     w;
      exp_t   e;
      while (q.size() > 0 && q[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_rvalid cyc=%0d actual=none expected=rvalid_at_%0d", cyc, q[0].due);
         void'(q.pop_front());
      end
      if (rst) begin
         check("gnt_in_reset", 32'(bus.gnt_o), 0);
         check("rvalid_in_reset", 32'(bus.rvalid_o), 0);
         check("rdata_in_reset", bus.rdata_o, 0);
         check("err_in_reset", 32'(bus.err_o), 0);
         q.delete();
      end else begin
         eg = bus.req_i & ~bus.stall_i & (q.size() < MO);
         check("gnt", 32'(bus.gnt_o), 32'(eg));
         check("outstanding", 32'(dut.cnt), 32'(q.size()));
         if (bus.rvalid_o) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid cyc=%0d actual=rvalid expected=none", cyc);
            end else begin
               e = q.pop_front();
               check("rsp_cycle", cyc, e.due);
               check("rsp_err", 32'(bus.err_o), 32'(e.err));
               check("rsp_rdata", bus.rdata_o, e.rdata);
            end
         end else begin
            check("idle_rdata", bus.rdata_o, 0);
            check("idle_err", 32'(bus.err_o), 0);
         end
         if (eg) begin
            a = longint'(bus.addr_i);
            inr = a >= longint'(BA) && a < longint'(BA) + longint'(MW) * 4;
            e.rdata = 0;
            if (inr) begin
               w = int'((a - longint'(BA)) / 4);
               if (bus.we_i) begin
                  for (int k = 0; k < 4; k++)
                     if (bus.be_i[k]) ref_mem[w][8*k +: 8] = bus.wdata_i[8*k +: 8];
               end else e.rdata = ref_mem[w];
            end
            e.err = !inr;
            e.due = cyc + L;
            q.push_back(e);
         end
      end
   end
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
      bit done = 0;
      bus.req_i   = 1;
      bus.we_i    = we;
      bus.addr_i  = addr;
      bus.be_i    = be;
      bus.wdata_i = wd;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = bus.gnt_o;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout cyc=%0d actual=no_gnt expected=gnt addr=%h", cyc, addr);
      end
      @(posedge clk);
      #1 bus.req_i = 0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      logic [31:0] a;
      bus.req_i = 0; bus.we_i = 0; bus.be_i = 0; bus.addr_i = 0; bus.wdata_i = 0; bus.stall_i = 0;
      idle(2);
      rst = 0;
      for (int w = 0; w < MW; w++) issue(1, BA + 32'(w) * 4, 4'hF, $urandom);
      issue(1, BA + 32'h10, 4'hF, 32'hDEADBEEF);
      issue(0, BA + 32'h10, 4'h0, 32'h0);
      issue(1, BA + 32'h20, 4'hF, 32'h11223344);
      issue(1, BA + 32'h20, 4'b0101, 32'hAABBCCDD);
      issue(0, BA + 32'h20, 4'h0, 32'h0);
      issue(1, BA + 32'h24, 4'h0, 32'hFFFFFFFF);
      issue(0, BA + 32'h27, 4'h0, 32'h0);
      idle(L + 2);
      for (int i = 0; i < 4; i++) issue(0, BA + 32'(i) * 4, 4'h0, 32'h0);
      idle(L + 2);
      issue(0, BA + MW * 4, 4'h0, 32'h0);
      issue(1, BA + MW * 4, 4'hF, 32'h55555555);
      issue(1, BA - 4, 4'hF, 32'h66666666);
      issue(0, BA + (MW - 1) * 4, 4'h0, 32'h0);
      issue(0, BA, 4'h0, 32'h0);
      idle(L + 2);
      issue(0, BA + 4, 4'h0, 32'h0);
      bus.stall_i = 1;
      fork
         issue(0, BA + 8, 4'h0, 32'h0);
         begin
            idle(5);
            bus.stall_i = 0;
         end
      join
      idle(L + 2);
      issue(0, BA + 12, 4'h0, 32'h0);
      issue(0, BA + 16, 4'h0, 32'h0);
      rst = 1;
      idle(1);
      rst = 0;
      idle(L + 3);
      rnd = 1;
      repeat (300) begin
         case ($urandom_range(0, 7))
            0: a = BA + MW * 4 + 32'($urandom_range(0, 255)) * 4;
            1: a = BA - 32'($urandom_range(1, 16)) * 4;
            default: a = BA + 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(0, 3));
         endcase
         issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rnd = 0;
      idle(1);
      bus.stall_i = 0;
      idle(L + 3);
      check("drained", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
